// File: rtl/mux_arb_nx1_if.sv
// Bundle of the channel handshakes and the single output port of mux_arb_nx1.
// The slave modport is the multiplexer; the master modport is the driver side
// (all producers plus the downstream consumer).
interface mux_arb_nx1_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS-1:0]       ready_out;
  logic                      mode_in;
  logic [SEL_W-1:0]          sel_in;
  logic [WIDTH-1:0]          y_out;
  logic                      y_valid_out;
  logic                      y_ready_in;
  logic [SEL_W-1:0]          y_chan_out;

  modport slave (
    input  data_in,
    input  valid_in,
    input  mode_in,
    input  sel_in,
    input  y_ready_in,
    output ready_out,
    output y_out,
    output y_valid_out,
    output y_chan_out
  );

  modport master (
    output data_in,
    output valid_in,
    output mode_in,
    output sel_in,
    output y_ready_in,
    input  ready_out,
    input  y_out,
    input  y_valid_out,
    input  y_chan_out
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// One channel is granted per cycle, either round-robin starting after the last
// winner or by an explicit select, and its word is captured into a
// single-entry output register that can refill in the same cycle it drains.
module mux_arb_nx1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input logic           clk_in,
  input logic           rst_n_in,
  mux_arb_nx1_if.slave  bus
);

  logic [WIDTH-1:0]    y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic [SEL_W-1:0]    y_chan_q, y_chan_d;
  logic [SEL_W-1:0]    last_grant_q, last_grant_d;

  logic                load;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W-1:0]    rr_cand;
  logic [CHANNELS-1:0] ready_d;

  // Pick the winning channel; nothing is granted while the output is stalled
  // or while reset is held, so no transfer can be recorded during reset.
  always_comb begin
    load      = !y_valid_q || bus.y_ready_in;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_cand   = '0;
    if (load && rst_n_in) begin
      if (bus.mode_in) begin
        if (int'(bus.sel_in) < CHANNELS) begin
          if (bus.valid_in[bus.sel_in]) begin
            grant_vld = 1'b1;
            grant_idx = bus.sel_in;
          end
        end
      end else begin
        for (int k = 1; k <= CHANNELS; k++) begin
          rr_cand = SEL_W'((int'(last_grant_q) + k) % CHANNELS);
          if (!grant_vld && bus.valid_in[rr_cand]) begin
            grant_vld = 1'b1;
            grant_idx = rr_cand;
          end
        end
      end
    end
  end

  // One-hot accept toward the granted producer only.
  always_comb begin
    ready_d = '0;
    if (grant_vld) begin
      ready_d[grant_idx] = 1'b1;
    end
  end

  // Next output-register contents: capture the winner, drain when emptied
  // without a refill, otherwise hold the current word untouched.
  always_comb begin
    y_d          = y_q;
    y_valid_d    = y_valid_q;
    y_chan_d     = y_chan_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      y_d          = bus.data_in[int'(grant_idx)*WIDTH +: WIDTH];
      y_chan_d     = grant_idx;
      y_valid_d    = 1'b1;
      last_grant_d = grant_idx;
    end else if (y_valid_q && bus.y_ready_in) begin
      y_valid_d = 1'b0;
    end
  end

  // Output stage and round-robin pointer; the pointer resets to the last
  // channel so that channel 0 is searched first after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      y_chan_q     <= '0;
      last_grant_q <= SEL_W'(CHANNELS - 1);
    end else begin
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      y_chan_q     <= y_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.ready_out   = ready_d;
  assign bus.y_out       = y_q;
  assign bus.y_valid_out = y_valid_q;
  assign bus.y_chan_out  = y_chan_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1: a 4-channel and a 5-channel instance share
// one clock and reset. Inputs change on the falling edge; ready_out is sampled
// 1 ns later and registered outputs 1 ns after the rising edge.
module tb_mux_arb_nx1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_arb_nx1_if #(.WIDTH(16), .CHANNELS(4)) bus4 ();
  mux_arb_nx1_if #(.WIDTH(16), .CHANNELS(5)) bus5 ();

  mux_arb_nx1 #(.WIDTH(16), .CHANNELS(4)) dut4 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus4)
  );

  mux_arb_nx1 #(.WIDTH(16), .CHANNELS(5)) dut5 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus5)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus4.data_in    = '0;
    bus4.valid_in   = '0;
    bus4.mode_in    = 1'b0;
    bus4.sel_in     = '0;
    bus4.y_ready_in = 1'b0;
    bus5.data_in    = '0;
    bus5.valid_in   = '0;
    bus5.mode_in    = 1'b0;
    bus5.sel_in     = '0;
    bus5.y_ready_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus4.valid_in   = 4'b1111;
    bus4.y_ready_in = 1'b1;
    #3;
    checks++; if (bus4.y_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_y_out got %h want 0000", bus4.y_out); end
    checks++; if (bus4.y_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_valid got %b want 0", bus4.y_valid_out); end
    checks++; if (bus4.y_chan_out !== 2'd0) begin errors++; $display("[TB] FAIL reset_y_chan got %0d want 0", bus4.y_chan_out); end
    checks++; if (bus4.ready_out !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b want 0000", bus4.ready_out); end
    checks++; if (bus5.y_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_valid5 got %b want 0", bus5.y_valid_out); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    do_reset();
    @(negedge clk);
    bus4.mode_in    = 1'b0;
    bus4.valid_in   = 4'b0100;
    bus4.data_in    = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
    bus4.y_ready_in = 1'b1;
    #1;
    checks++; if (bus4.ready_out !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready got %b want 0100", bus4.ready_out); end
    @(posedge clk); #1;
    checks++; if (bus4.y_out !== 16'h1234) begin errors++; $display("[TB] FAIL single_y_out got %h want 1234", bus4.y_out); end
    checks++; if (bus4.y_chan_out !== 2'd2) begin errors++; $display("[TB] FAIL single_y_chan got %0d want 2", bus4.y_chan_out); end
    checks++; if (bus4.y_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL single_y_valid got %b want 1", bus4.y_valid_out); end
    @(negedge clk);
    bus4.valid_in = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_chan;
    logic [15:0] exp_data;
    do_reset();
    @(negedge clk);
    bus4.mode_in    = 1'b0;
    bus4.valid_in   = 4'b1111;
    bus4.data_in    = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    bus4.y_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_chan = 2'(i % 4);
      exp_data = 16'hA000 + 16'(i % 4);
      @(posedge clk); #1;
      checks++; if (bus4.y_chan_out !== exp_chan) begin errors++; $display("[TB] FAIL rr_chan[%0d] got %0d want %0d", i, bus4.y_chan_out, exp_chan); end
      checks++; if (bus4.y_out !== exp_data) begin errors++; $display("[TB] FAIL rr_data[%0d] got %h want %h", i, bus4.y_out, exp_data); end
      checks++; if (bus4.y_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid[%0d] got %b want 1", i, bus4.y_valid_out); end
    end
    @(negedge clk);
    bus4.valid_in = 4'b0000;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    bus4.mode_in    = 1'b0;
    bus4.valid_in   = 4'b0010;
    bus4.data_in    = {16'h3330, 16'h2220, 16'h00AA, 16'h1110};
    bus4.y_ready_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus4.y_out !== 16'h00AA) begin errors++; $display("[TB] FAIL stall_load got %h want 00aa", bus4.y_out); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus4.valid_in   = 4'b1111;
      bus4.y_ready_in = 1'b0;
      #1;
      checks++; if (bus4.ready_out !== 4'b0000) begin errors++; $display("[TB] FAIL stall_ready[%0d] got %b want 0000", i, bus4.ready_out); end
      @(posedge clk); #1;
      checks++; if (bus4.y_out !== 16'h00AA) begin errors++; $display("[TB] FAIL stall_y_out[%0d] got %h want 00aa", i, bus4.y_out); end
      checks++; if (bus4.y_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, bus4.y_valid_out); end
    end
    @(negedge clk);
    bus4.y_ready_in = 1'b1;
    #1;
    checks++; if (bus4.ready_out !== 4'b0100) begin errors++; $display("[TB] FAIL unstall_ready got %b want 0100", bus4.ready_out); end
    @(posedge clk); #1;
    checks++; if (bus4.y_out !== 16'h2220) begin errors++; $display("[TB] FAIL unstall_y_out got %h want 2220", bus4.y_out); end
    checks++; if (bus4.y_chan_out !== 2'd2) begin errors++; $display("[TB] FAIL unstall_chan got %0d want 2", bus4.y_chan_out); end
    @(negedge clk);
    bus4.valid_in = 4'b0000;
  endtask

  task automatic test_fixed_select();
    do_reset();
    @(negedge clk);
    bus4.mode_in    = 1'b1;
    bus4.sel_in     = 2'd3;
    bus4.valid_in   = 4'b1001;
    bus4.data_in    = {16'h0C33, 16'h0000, 16'h0000, 16'h0C00};
    bus4.y_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus4.ready_out !== 4'b1000) begin errors++; $display("[TB] FAIL sel_ready[%0d] got %b want 1000", i, bus4.ready_out); end
      @(posedge clk); #1;
      checks++; if (bus4.y_chan_out !== 2'd3) begin errors++; $display("[TB] FAIL sel_chan[%0d] got %0d want 3", i, bus4.y_chan_out); end
      checks++; if (bus4.y_out !== 16'h0C33) begin errors++; $display("[TB] FAIL sel_y_out[%0d] got %h want 0c33", i, bus4.y_out); end
    end
    @(negedge clk);
    bus4.valid_in = 4'b0001;
    #1;
    checks++; if (bus4.ready_out !== 4'b0000) begin errors++; $display("[TB] FAIL sel_nogrant_ready got %b want 0000", bus4.ready_out); end
    @(posedge clk); #1;
    checks++; if (bus4.y_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL sel_drain_valid got %b want 0", bus4.y_valid_out); end
    checks++; if (bus4.y_out !== 16'h0C33) begin errors++; $display("[TB] FAIL sel_drain_hold got %h want 0c33", bus4.y_out); end
    checks++; if (bus4.y_chan_out !== 2'd3) begin errors++; $display("[TB] FAIL sel_drain_chan got %0d want 3", bus4.y_chan_out); end
    @(negedge clk);
    bus4.valid_in = 4'b0000;
    bus4.mode_in  = 1'b0;
  endtask

  task automatic test_out_of_range_select();
    do_reset();
    @(negedge clk);
    bus5.mode_in    = 1'b1;
    bus5.sel_in     = 3'd6;
    bus5.valid_in   = 5'b11111;
    bus5.data_in    = {16'h5004, 16'h5003, 16'h5002, 16'h5001, 16'h5000};
    bus5.y_ready_in = 1'b1;
    #1;
    checks++; if (bus5.ready_out !== 5'b00000) begin errors++; $display("[TB] FAIL oor_ready got %b want 00000", bus5.ready_out); end
    @(posedge clk); #1;
    checks++; if (bus5.y_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL oor_valid got %b want 0", bus5.y_valid_out); end
    @(negedge clk);
    bus5.sel_in = 3'd4;
    #1;
    checks++; if (bus5.ready_out !== 5'b10000) begin errors++; $display("[TB] FAIL sel4_ready got %b want 10000", bus5.ready_out); end
    @(posedge clk); #1;
    checks++; if (bus5.y_chan_out !== 3'd4) begin errors++; $display("[TB] FAIL sel4_chan got %0d want 4", bus5.y_chan_out); end
    checks++; if (bus5.y_out !== 16'h5004) begin errors++; $display("[TB] FAIL sel4_y_out got %h want 5004", bus5.y_out); end
    @(negedge clk);
    bus5.valid_in = 5'b00000;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk);
    bus4.mode_in    = 1'b0;
    bus4.valid_in   = 4'b0100;
    bus4.data_in    = {16'h7773, 16'h7772, 16'h7771, 16'h7770};
    bus4.y_ready_in = 1'b1;
    @(negedge clk);
    bus4.valid_in   = 4'b1111;
    bus4.y_ready_in = 1'b0;
    #1;
    checks++; if (bus4.y_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid got %b want 1", bus4.y_valid_out); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.y_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b want 0", bus4.y_valid_out); end
    checks++; if (bus4.y_out !== 16'h0000) begin errors++; $display("[TB] FAIL mid_rst_y_out got %h want 0000", bus4.y_out); end
    @(negedge clk);
    rst_n = 1'b1;
    bus4.y_ready_in = 1'b1;
    #1;
    checks++; if (bus4.ready_out !== 4'b0001) begin errors++; $display("[TB] FAIL post_rst_ready got %b want 0001", bus4.ready_out); end
    @(posedge clk); #1;
    checks++; if (bus4.y_chan_out !== 2'd0) begin errors++; $display("[TB] FAIL post_rst_chan got %0d want 0", bus4.y_chan_out); end
    checks++; if (bus4.y_out !== 16'h7770) begin errors++; $display("[TB] FAIL post_rst_y_out got %h want 7770", bus4.y_out); end
    @(negedge clk);
    bus4.valid_in = 4'b0000;
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_fixed_select();
    test_out_of_range_select();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Selects one requesting channel per cycle, either by round-robin arbitration or by an explicit select.
- Registers the winner into a single-entry output stage with backpressure.
- Successor to the fixed 4:1 16-bit mux tree. Used wherever several producers share one 16-bit datapath consumer, e.g. memory or bus ports.

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- CHANNELS, 4, number of input channels. Legal range 2..16.
- SEL_W, $clog2(CHANNELS), select/channel-index width. Derived; must not be overridden.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- data_in  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_in  input  CHANNELS  per-channel request/valid.
- ready_out  output  CHANNELS  per-channel accept; at most one bit set.
- mode_in  input  1  0 = round-robin, 1 = fixed select.
- sel_in  input  SEL_W  channel index used when mode_in=1.
- y_out  output  WIDTH  registered output data.
- y_valid_out  output  1  output register holds valid data.
- y_ready_in  input  1  downstream accepts y_out this cycle.
- y_chan_out  output  SEL_W  index of the channel that produced y_out.

Behaviour:
- Interface (decided): one clock (clk_in); reset rst_n_in is asynchronous, active-low.
- Reset values: y_out=0, y_valid_out=0, y_chan_out=0, ready_out=0, last_grant=CHANNELS-1 (so channel 0 has first priority after reset). Reset takes effect immediately, independent of clk_in.
- Load enable: load = !y_valid_out || y_ready_in. The output register can take new data in the same cycle that its current word drains (full throughput, 1 word/cycle).
- Grant (combinational, evaluated only when load=1; otherwise no grant):
  - mode_in=0: the first i with valid_in[i]=1, searching from (last_grant+1) mod CHANNELS upward with wrap-around.
  - mode_in=1: grant = sel_in if sel_in < CHANNELS and valid_in[sel_in]=1; otherwise no grant. Out-of-range sel_in never grants.
- ready_out[g] = 1 only for the granted channel g, else all zeros.
  - Combinational path valid_in -> ready_out is permitted.
  - Producers must not make valid_in depend on ready_out.
- Transfer on the rising edge where valid_in[g] && ready_out[g]:
  - y_out <= data_in channel g; y_chan_out <= g; y_valid_out <= 1; last_grant <= g.
  - last_grant updates in both modes.
- Drain without refill: y_valid_out && y_ready_in with no grant -> y_valid_out <= 0. y_out and y_chan_out hold their last values.
- Stall: y_valid_out && !y_ready_in -> y_out, y_chan_out, y_valid_out stable; ready_out all zero.
- Latency: accepted word appears on y_out exactly 1 cycle after the accept edge.
- Mode/select changes take effect on the next grant evaluation. A word already held is never dropped or altered.
- Fairness (mode 0): with all channels continuously requesting and no stall, the grant sequence is 0,1,..,CHANNELS-1,0,... No channel waits more than CHANNELS-1 grants.
- Reset asserted mid-operation: the held word is discarded and all state returns to reset values. No transfer is recorded on the edge where reset is low.
- No data reordering within a channel; one word per channel per grant.

Test Plan:
- Reset, then channel 2 alone valid with data 0x1234 (mode 0) -> ready_out=0100 in cycle 0; next cycle y_out=0x1234, y_chan_out=2, y_valid_out=1.
- All 4 channels valid with data 0xA000+i, y_ready_in=1 held, mode 0 -> y_chan_out sequence 0,1,2,3,0 on consecutive cycles, y_valid_out stays 1.
- Output holds 0x00AA, y_ready_in=0 for 3 cycles while channels valid -> y_out stable at 0x00AA, ready_out=0000 for all 3 cycles. On y_ready_in=1, the next word loads in the same cycle.
- mode_in=1, sel_in=3, channels 0 and 3 valid -> only channel 3 granted repeatedly. Then with valid_in[3]=0 -> no grant; y_valid_out falls after the drain.
- CHANNELS=5 build, mode_in=1, sel_in=6 with all valid -> ready_out=00000 and no transfer. sel_in=4 -> channel 4 granted.
- Assert rst_n_in mid-stall with y_valid_out=1 -> y_valid_out=0 and y_out=0 immediately. After release, channel 0 has first priority.
